// File: rtl/syn_fifo_pkg.sv
// ============================================================================
// Module   : syn_fifo_pkg
// Purpose  : Shared types and helpers for the syn_fifo_flags FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package syn_fifo_pkg;

  // Indexed by {rd_acc, wr_acc}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10,
    BOTH = 2'b11
  } fifo_op_e;

  function automatic int ptr_w(input int dep);
    return $clog2(dep) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/syn_fifo_mem.sv
// ============================================================================
// Module   : syn_fifo_mem
// Purpose  : FIFO storage, one synchronous write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_fifo_mem #(
  parameter int DEP  = 8,
  parameter int DWID = 16
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEP)-1:0]   waddr_i,
  input  logic [DWID-1:0]          wdata_i,
  input  logic [$clog2(DEP)-1:0]   raddr_i,
  output logic [DWID-1:0]          rdata_o
);

  // No reset so the array maps onto RAM.
  logic [DWID-1:0] mem_q [DEP];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/syn_fifo_flags.sv
// ============================================================================
// Module   : syn_fifo_flags
// Purpose  : Synchronous FIFO with fill count, threshold flags, FWFT or
//            registered read, flush and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_fifo_flags
  import syn_fifo_pkg::*;
#(
  parameter int DEP    = 8,
  parameter int DWID   = 16,
  parameter int AF_LVL = DEP - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   wr_i,
  input  logic [DWID-1:0]        wdata,
  input  logic                   rd_i,
  output logic [DWID-1:0]        rdata,
  output logic                   rvalid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   afull_o,
  output logic                   aempty_o,
  output logic [$clog2(DEP):0]   count_o,
  output logic                   ovf_err_o,
  output logic                   udf_err_o,
  input  logic                   err_clr_i
);

  localparam int PW = ptr_w(DEP);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_C = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LVL);

  logic [PW-1:0]   wrptr_q, wrptr_d;
  logic [PW-1:0]   rdptr_q, rdptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            full, empty;
  logic            wr_acc, rd_acc;
  logic            ovf_ev, udf_ev;
  logic [DWID-1:0] mem_rdata;
  fifo_op_e        op;

  // Wrap bit differs with equal low bits: writer is a full lap ahead.
  assign full  = (wrptr_q[PW-1] != rdptr_q[PW-1]) &&
                 (wrptr_q[AW-1:0] == rdptr_q[AW-1:0]);
  assign empty = (wrptr_q == rdptr_q);

  assign rd_acc = rd_i & ~empty & ~flush_i;
  assign wr_acc = wr_i & (~full | rd_acc) & ~flush_i;
  assign ovf_ev = wr_i & ~wr_acc & ~flush_i;
  assign udf_ev = rd_i & empty & ~flush_i;
  assign op     = fifo_op_e'({rd_acc, wr_acc});

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    if (flush_i) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wrptr_d = wrptr_q + 1'b1;
      if (rd_acc) rdptr_d = rdptr_q + 1'b1;
      unique case (op)
        WR:      count_d = count_q + 1'b1;
        RD:      count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // A new error event in the same cycle as a clear keeps the flag set.
  assign ovf_d = (ovf_q & ~err_clr_i) | ovf_ev;
  assign udf_d = (udf_q & ~err_clr_i) | udf_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  syn_fifo_mem #(
    .DEP  (DEP),
    .DWID (DWID)
  ) u_mem (
    .clk     (clk),
    .wr_en_i (wr_acc),
    .waddr_i (wrptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rdptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata    = mem_rdata;
      assign rvalid_o = ~empty;
    end else begin : g_regrd
      logic [DWID-1:0] rdata_q;
      logic            rvalid_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_acc;
          if (rd_acc) rdata_q <= mem_rdata;
        end
      end

      assign rdata    = rdata_q;
      assign rvalid_o = rvalid_q;
    end
  endgenerate

  assign full_o    = full;
  assign empty_o   = empty;
  assign afull_o   = (count_q >= AF_C);
  assign aempty_o  = (count_q <= AE_C);
  assign count_o   = count_q;
  assign ovf_err_o = ovf_q;
  assign udf_err_o = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_syn_fifo_flags.sv
// Directed bench: FWFT=1 instance for flags/ordering, FWFT=0 instance for
// registered-read latency; read data checked by queue-based monitors.
`default_nettype none

module tb_syn_fifo_flags;

  logic        clk, rst, flush_i, err_clr_i;
  logic        wr_i, rd_i;
  logic [15:0] wdata, rdata;
  logic        rvalid_o, full_o, empty_o, afull_o, aempty_o, ovf_err_o, udf_err_o;
  logic [2:0]  count_o;

  logic        wr0, rd0;
  logic [15:0] wdata0, rdata0;
  logic        rvalid0, full0, empty0, afull0, aempty0, ovf0, udf0;
  logic [2:0]  count0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp0_q[$];
  logic [15:0] exp_w, exp_w0;

  syn_fifo_flags #(.DEP(4), .DWID(16), .AF_LVL(3), .AE_LVL(1), .FWFT(1)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wr_i(wr_i), .wdata(wdata),
    .rd_i(rd_i), .rdata(rdata), .rvalid_o(rvalid_o), .full_o(full_o),
    .empty_o(empty_o), .afull_o(afull_o), .aempty_o(aempty_o),
    .count_o(count_o), .ovf_err_o(ovf_err_o), .udf_err_o(udf_err_o),
    .err_clr_i(err_clr_i)
  );

  syn_fifo_flags #(.DEP(4), .DWID(16), .AF_LVL(3), .AE_LVL(1), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wr_i(wr0), .wdata(wdata0),
    .rd_i(rd0), .rdata(rdata0), .rvalid_o(rvalid0), .full_o(full0),
    .empty_o(empty0), .afull_o(afull0), .aempty_o(aempty0),
    .count_o(count0), .ovf_err_o(ovf0), .udf_err_o(udf0),
    .err_clr_i(err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle on the FWFT=1 instance; returns at posedge+1.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                     input logic f, input logic c);
    wr_i = w; wdata = d; rd_i = r; flush_i = f; err_clr_i = c;
    @(posedge clk); #1;
    wr_i = 1'b0; rd_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic cyc0(input logic w, input logic [15:0] d, input logic r);
    wr0 = w; wdata0 = d; rd0 = r;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  // FWFT=1: data is consumed when a read is requested while valid.
  always @(negedge clk) begin
    if (rst && rd_i && rvalid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %0h expected none", rdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (rdata !== exp_w) begin
          errors++;
          $display("FAIL rdata: got %0h expected %0h", rdata, exp_w);
        end
      end
    end
  end

  // FWFT=0: data is presented with the rvalid pulse.
  always @(negedge clk) begin
    if (rst && rvalid0) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("FAIL rdata0_unexpected: got %0h expected none", rdata0);
      end else begin
        exp_w0 = exp0_q.pop_front();
        if (rdata0 !== exp_w0) begin
          errors++;
          $display("FAIL rdata0: got %0h expected %0h", rdata0, exp_w0);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
    wr_i = 1'b0; rd_i = 1'b0; wdata = '0;
    wr0 = 1'b0; rd0 = 1'b0; wdata0 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_aempty", aempty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_afull", afull_o, 0);
    chk("rst_ovf", ovf_err_o, 0);
    chk("rst_udf", udf_err_o, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rdata0", rdata0, 0);

    // Three fill/drain rounds walk the pointers across the wrap.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, 16'(rnd * 256 + i + 1), 1'b0, 1'b0, 1'b0);
        chk("fill_count", count_o, i + 1);
        chk("fill_empty", empty_o, 0);
        chk("fill_aempty", aempty_o, (i == 0) ? 1 : 0);
        chk("fill_afull", afull_o, (i >= 2) ? 1 : 0);
        chk("fill_full", full_o, (i == 3) ? 1 : 0);
      end
      cyc(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", ovf_err_o, 1);
      chk("ovf_count", count_o, 4);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr", ovf_err_o, 0);
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(16'(rnd * 256 + i + 1));
        cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("drain_count", count_o, 3 - i);
      end
      chk("drain_empty", empty_o, 1);
      chk("drain_udf", udf_err_o, 0);
    end

    // Pass-through at full.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0011 + i), 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'h0011);
    cyc(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
    chk("pt_count", count_o, 4);
    chk("pt_full", full_o, 1);
    chk("pt_ovf", ovf_err_o, 0);
    exp_q.push_back(16'h0012);
    exp_q.push_back(16'h0013);
    exp_q.push_back(16'h0014);
    exp_q.push_back(16'h00AA);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("pt_empty", empty_o, 1);

    // Simultaneous write and read at empty: no bypass.
    cyc(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    chk("es_udf", udf_err_o, 1);
    chk("es_count", count_o, 1);
    chk("es_rdata", rdata, 16'h1234);
    chk("es_rvalid", rvalid_o, 1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("es_udf_clr", udf_err_o, 0);
    exp_q.push_back(16'h1234);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("es_empty", empty_o, 1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("set_wins_udf", udf_err_o, 1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("udf_clr2", udf_err_o, 0);

    // Registered-read latency on the FWFT=0 instance.
    cyc0(1'b1, 16'hBEEF, 1'b0);
    chk("r0_rvalid_idle", rvalid0, 0);
    chk("r0_count", count0, 1);
    exp0_q.push_back(16'hBEEF);
    cyc0(1'b0, 16'h0000, 1'b1);
    chk("r0_rvalid", rvalid0, 1);
    chk("r0_rdata", rdata0, 16'hBEEF);
    cyc0(1'b0, 16'h0000, 1'b0);
    chk("r0_rvalid_pulse", rvalid0, 0);
    chk("r0_rdata_hold", rdata0, 16'hBEEF);
    chk("r0_empty", empty0, 1);

    // Flush at count 3 drops a concurrent write.
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0021 + i), 1'b0, 1'b0, 1'b0);
    chk("fl_pre_count", count_o, 3);
    cyc(1'b1, 16'h0099, 1'b0, 1'b1, 1'b0);
    chk("fl_count", count_o, 0);
    chk("fl_empty", empty_o, 1);
    chk("fl_ovf", ovf_err_o, 0);
    chk("fl_udf", udf_err_o, 0);
    cyc(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(16'h0055);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("fl_post_empty", empty_o, 1);

    // Asynchronous reset in the middle of a write cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0031 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0035, 1'b0, 1'b0, 1'b0);
    chk("ar_pre_ovf", ovf_err_o, 1);
    wr_i = 1'b1; wdata = 16'h0036;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", count_o, 0);
    chk("ar_empty", empty_o, 1);
    chk("ar_aempty", aempty_o, 1);
    chk("ar_full", full_o, 0);
    chk("ar_afull", afull_o, 0);
    chk("ar_ovf", ovf_err_o, 0);
    wr_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp0_q_drained", exp0_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/syn_fifo_flags.md
Name: syn_fifo_flags

Overview:
- Next-generation parametrised synchronous FIFO; drop-in successor for the plain pointer-compare FIFO used between datapath stages.
- Adds:
  - fill count
  - programmable almost-full and almost-empty thresholds
  - selectable first-word-fall-through (FWFT) or registered-read mode
  - pass-through write at full
  - synchronous flush
  - sticky overflow/underflow error flags
- Single clock domain. Instances sit wherever producer/consumer rates differ but share a clock.

Parameters:
- DEP, 8, depth in words; power of two, >=2.
- DWID, 16, data width in bits.
- AF_LVL, DEP-2, afull_o asserted when count >= AF_LVL; range 1..DEP.
- AE_LVL, 2, aempty_o asserted when count <= AE_LVL; range 0..DEP-1.
- FWFT, 1, 1 = show-ahead read data; 0 = registered read data, one-cycle latency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous empty request.
- wr_i  in  1  write request.
- wdata  in  DWID  write data.
- rd_i  in  1  read/pop request.
- rdata  out  DWID  read data.
- rvalid_o  out  1  FWFT=1: equals !empty_o. FWFT=0: one-cycle pulse, rdata valid.
- full_o  out  1  count == DEP.
- empty_o  out  1  count == 0.
- afull_o  out  1  count >= AF_LVL.
- aempty_o  out  1  count <= AE_LVL.
- count_o  out  $clog2(DEP)+1  words stored, 0..DEP.
- ovf_err_o  out  1  sticky: write attempted while full and not accepted.
- udf_err_o  out  1  sticky: read attempted while empty.
- err_clr_i  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst=0, async assert, sync release):
  - wrptr, rdptr, count_o = 0; empty_o=1, aempty_o=1; full_o, afull_o, rvalid_o = 0 (FWFT=0); error flags = 0.
  - rdata = 0 in FWFT=0.
  - Memory array is NOT reset (RAM inference).
- Pointers: $clog2(DEP)+1 bits, increment by exactly 1 per accepted op. MSB is the wrap bit.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
  - Wrap from DEP-1 to 0 is seamless.
- Read acceptance: rd_acc = rd_i & !empty_o.
- Write acceptance: wr_acc = wr_i & (!full_o | rd_acc). Simultaneous write and read at full is accepted; count unchanged.
- At empty, simultaneous write and read: write accepted, read rejected (no bypass). udf_err_o sets.
- count_o next value:
  - count + wr_acc - rd_acc
  - registered, updated same edge as the pointers.
  - All flags are combinational from the registered count/pointers, so flags change the cycle after the causing edge.
- FWFT=1:
  - rdata = mem[rdptr low bits], combinational.
  - Valid whenever !empty_o.
  - Undefined (don't-care) when empty.
- FWFT=0:
  - On rd_acc, rdata is loaded with mem[rdptr] at the clock edge; rvalid_o=1 for the following cycle only.
  - rdata holds its value otherwise.
- Write: on wr_acc, mem[wrptr low bits] <= wdata at the clock edge.
- Flush:
  - flush_i=1 sets wrptr = rdptr = count = 0 next edge.
  - Overrides wr_i/rd_i that cycle; no acceptance, no error flagging.
  - Clears rvalid_o. Memory and error flags are unaffected.
- Errors:
  - ovf_err_o sets on wr_i & !wr_acc.
  - udf_err_o sets on rd_i & empty_o.
  - Both hold until err_clr_i or reset.
  - If err_clr_i coincides with a new error event, set wins.
- Rejected ops change no state other than the error flags.

Decomposition:
- Package syn_fifo_pkg holds:
  - enum fifo_op_e {IDLE=2'b00, WR=2'b01, RD=2'b10, BOTH=2'b11}, indexed by {rd_acc, wr_acc}
  - function ptr_w(dep) returning $clog2(dep)+1
- Sub-module syn_fifo_mem(DEP, DWID): storage array.
  - 1 synchronous write port.
  - 1 read port, combinational address-to-data; registering is done in the parent per FWFT.
- Parent holds pointers, count, flags, errors and the read register.

Test Plan:
- Bench configuration for all scenarios: DEP=4, DWID=16, AF_LVL=3, AE_LVL=1, FWFT=1 unless noted.
- Reset check: hold rst=0 two cycles. Then count_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, ovf_err_o=0, udf_err_o=0.
- Fill and drain with wrap:
  - Write 0x0001..0x0004. Flags read afull_o=1 at count 3 and full_o=1 at count 4.
  - Write 0x0005 is rejected; ovf_err_o=1 and count stays 4.
  - Drain yields 0001..0004 in order; empty_o=1 after the 4th read.
  - Repeat twice to cross the pointer wrap.
- Full pass-through: at count 4, assert wr_i=1 (0x00AA) and rd_i=1 in the same cycle.
  - Read returns the head word; count stays 4; ovf_err_o stays 0.
  - 0x00AA emerges 4 reads later.
- Empty simultaneous: at count 0, assert wr_i=1 (0x1234) and rd_i=1.
  - udf_err_o=1, count=1.
  - Next cycle rdata=0x1234.
  - err_clr_i pulse clears udf_err_o.
- FWFT=0 latency: write 0xBEEF, then read.
  - rvalid_o=1 and rdata=0xBEEF exactly one cycle after the rd_i cycle.
  - rdata holds 0xBEEF afterwards.
- Flush and mid-operation reset:
  - Case 1: at count 3, flush_i=1 with wr_i=1. Next cycle count=0, empty_o=1; the write is dropped.
  - Case 2: separately, assert rst=0 asynchronously mid-write. Outputs reach reset values immediately, without waiting for a clock edge.
